jamma_joy_scan_ctrl: RTL and testbench
======================================

# jamma_joy_scan_ctrl

Sequencer for the JAMMA joystick splitter. Drives the shared `JSELECT` line and waits a settle time after each switch. It then samples the multiplexed `JJOY` bus until a configurable number of consecutive identical samples are seen, and publishes both players' joystick words at the same time with a valid strobe. It sits between the board pins and the per-player button/debounce logic, and replaces free-running select toggling with a deterministic, glitch-filtered scan.

## Interface
- `SETTLE`, 8: cycles held in each settle state after `JSELECT` changes (≥1).
- `SAMPLES`, 3: consecutive identical samples required to accept a player word (≥1).
- `TIMEOUT`, 16: maximum sample cycles per player before giving up (≥ `SAMPLES`).

- `CLK_12M` in 1: sole clock.
- `RESET_N` in 1: asynchronous, active-low reset.
- `ENABLE` in 1: scanning runs while high.
- `JJOY` in 8: multiplexed splitter bus, active-low.
- `JOYSTICK` in 6: local DB9 joystick, active-low; merged into player 1 only.
- `JSELECT` out 1: splitter select; 0 selects player 1, 1 selects player 2.
- `JOY1` out 8: accepted player-1 word, active-low.
- `JOY2` out 8: accepted player-2 word, active-low.
- `JOY_VALID` out 1: one-cycle pulse when `JOY1`/`JOY2` are updated.
- `JOY_ERR` out 2: per-frame timeout flags; bit0 is P1, bit1 is P2. Updated with `JOY_VALID`.

## Operation
- States: IDLE, SETTLE1, SAMPLE1, SETTLE2, SAMPLE2, PUBLISH.
- IDLE: `JSELECT`=0. When `ENABLE`=1, go to SETTLE1.
- SETTLE1 / SETTLE2: `JSELECT` is 0 / 1. Down-counter loaded with `SETTLE`-1 on entry; leave when it reaches 0. The state lasts exactly `SETTLE` cycles, and no sampling happens.
- SAMPLE1:
  - Sample word is `JJOY & {2'b11, JOYSTICK}`.
  - First cycle stores the sample as the candidate, with match count 1.
  - Each later cycle: if the sample equals the candidate, count+1. Otherwise the candidate becomes the new sample and count=1.
  - When count reaches `SAMPLES`, latch the candidate into the P1 staging register, clear err1, and go to SETTLE2.
- SAMPLE2: identical to SAMPLE1 with sample word `JJOY`. On success go to PUBLISH.
- Timeout: a sample-cycle counter counts cycles spent in the current SAMPLE state. If `TIMEOUT` cycles elapse without reaching `SAMPLES`:
  - The staging register keeps its previous value (the last accepted word).
  - The err bit for that player is set.
  - The FSM proceeds as it would on success.
- PUBLISH: load `JOY1`, `JOY2` and `JOY_ERR` from staging, and pulse `JOY_VALID`. Then go to SETTLE1 if `ENABLE`=1, else IDLE.
- `ENABLE` is only examined in IDLE and PUBLISH. Dropping it mid-frame completes the current frame.
- Match-count and timeout counters are sized for `TIMEOUT`; no wrap is possible before exit.

## Timing
- Reset values: state IDLE, `JSELECT`=0, `JOY1`=`JOY2`=8'hFF, `JOY_VALID`=0, `JOY_ERR`=2'b00, staging registers 8'hFF, all counters 0.
- All outputs are registered.
- `JSELECT` changes on the edge that enters SETTLE2 (0→1) and on the edge that leaves PUBLISH (1→0).
- `JOY1`/`JOY2`/`JOY_ERR` change, and `JOY_VALID` is high, in the cycle after PUBLISH. No other cycle pulses `JOY_VALID`.
- Clean frame length: 2×(`SETTLE`+`SAMPLES`)+1 cycles, which is 23 with defaults. `JOY_VALID` period when continuously enabled is 23 cycles.
- First `JOY_VALID` after `ENABLE` rises in IDLE: 1 IDLE cycle plus 23 cycles, so it appears in the 25th cycle after the first cycle `ENABLE` is sampled high.
- Worst-case frame (both players time out): 2×(`SETTLE`+`TIMEOUT`)+1 = 49 cycles.
- A sample taken in the last settle cycle is never used. The first sample is taken in the first SAMPLE-state cycle.
- `RESET_N` low at any point (including mid-SAMPLE) immediately forces all reset values; a partial frame is discarded.

## Test plan
- Reset: hold `RESET_N`=0 with arbitrary inputs → `JSELECT`=0, `JOY1`=`JOY2`=8'hFF, `JOY_VALID`=0, `JOY_ERR`=0.
- Static frame: `JJOY`=8'hA5 while `JSELECT`=0, 8'h5A while `JSELECT`=1; `JOYSTICK`=6'b111110; `ENABLE`=1 → `JOY1`=8'hA4, `JOY2`=8'h5A, `JOY_ERR`=0; `JOY_VALID` pulses every 23 cycles.
- Bounce: during SAMPLE1, `JJOY` takes 8'hF0 for 2 cycles, then 8'hF1, then steady 8'hF0 → P1 accepted after the bounce settles, `JOY1`=8'hF0 (`JOYSTICK`=6'h3F), frame lengthened by exactly 3 cycles.
- Timeout: toggle P2 `JJOY` every cycle between 8'h00 and 8'hFF → `JOY_ERR`=2'b10, `JOY2` holds its previous value, frame length 23-3+16=36 cycles.
- `ENABLE` cleared during SETTLE2 → frame completes with one `JOY_VALID`, `JSELECT` returns to 0, FSM idles, no further pulses.
- `RESET_N` asserted mid-SAMPLE2 → outputs return to reset values at once; after release with `ENABLE`=1, the next `JOY_VALID` arrives in the 25th cycle after the first cycle `ENABLE` is sampled high.

Source files
------------

// File: rtl/jamma_joy_scan_if.sv
// Pin-side bundle of the JAMMA joystick splitter sequencer: enable, the
// multiplexed splitter bus and local joystick in; select line and the
// accepted per-player words out.
interface jamma_joy_scan_if;
    logic       ENABLE;
    logic [7:0] JJOY;
    logic [5:0] JOYSTICK;
    logic       JSELECT;
    logic [7:0] JOY1;
    logic [7:0] JOY2;
    logic       JOY_VALID;
    logic [1:0] JOY_ERR;

    // Sequencer side
    modport master (
        input  ENABLE, JJOY, JOYSTICK,
        output JSELECT, JOY1, JOY2, JOY_VALID, JOY_ERR
    );

    // Board / consumer side
    modport slave (
        output ENABLE, JJOY, JOYSTICK,
        input  JSELECT, JOY1, JOY2, JOY_VALID, JOY_ERR
    );
endinterface

// File: rtl/jamma_joy_scan_ctrl.sv
// JAMMA joystick splitter sequencer. Selects player 1, settles, samples until
// SAMPLES consecutive identical words (or TIMEOUT cycles), then does the same
// for player 2 and publishes both words together with a one-cycle valid.
module jamma_joy_scan_ctrl #(
    parameter int SETTLE  = 8,
    parameter int SAMPLES = 3,
    parameter int TIMEOUT = 16
) (
    input  logic                CLK_12M,
    input  logic                RESET_N,
    jamma_joy_scan_if.master    bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE1,
        S_SAMPLE1,
        S_SETTLE2,
        S_SAMPLE2,
        S_PUBLISH
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [SW-1:0]   r_scnt;
    logic [CW-1:0]   r_tcnt;
    logic [CW-1:0]   r_mcnt;
    logic [7:0]      r_cand;
    logic [7:0]      r_stg1;
    logic [7:0]      r_stg2;
    logic            r_err1;
    logic            r_err2;
    logic            r_jsel;
    logic [7:0]      r_joy1;
    logic [7:0]      r_joy2;
    logic            r_valid;
    logic [1:0]      r_err;

    logic [7:0]      w_sample;
    logic            w_in_sample;
    logic            w_match;
    logic [CW-1:0]   w_mcnt_nxt;
    logic [CW-1:0]   w_tcnt_nxt;
    logic            w_accept;
    logic            w_tmo;
    logic            w_done;

    // Glitch filter: candidate match counting and sample-window timeout
    always_comb begin
        w_in_sample = (r_state == S_SAMPLE1) || (r_state == S_SAMPLE2);
        w_sample    = (r_state == S_SAMPLE1) ? (bus.JJOY & {2'b11, bus.JOYSTICK}) : bus.JJOY;
        // r_tcnt == 0 marks the first cycle of a sample window: no candidate yet
        w_match     = (r_tcnt != '0) && (w_sample == r_cand);
        w_mcnt_nxt  = w_match ? (r_mcnt + 1'b1) : CW'(1);
        w_tcnt_nxt  = r_tcnt + 1'b1;
        w_accept    = w_in_sample && (w_mcnt_nxt == CW'(SAMPLES));
        w_tmo       = w_in_sample && !w_accept && (w_tcnt_nxt == CW'(TIMEOUT));
        w_done      = w_accept || w_tmo;
    end

    // Next-state decode; ENABLE only matters at frame boundaries
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (bus.ENABLE) w_state_nxt = S_SETTLE1;
            S_SETTLE1: if (r_scnt == '0) w_state_nxt = S_SAMPLE1;
            S_SAMPLE1: if (w_done) w_state_nxt = S_SETTLE2;
            S_SETTLE2: if (r_scnt == '0) w_state_nxt = S_SAMPLE2;
            S_SAMPLE2: if (w_done) w_state_nxt = S_PUBLISH;
            S_PUBLISH: w_state_nxt = bus.ENABLE ? S_SETTLE1 : S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK_12M or negedge RESET_N) begin
        if (!RESET_N) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Settle down-counter, reloaded whenever a settle state is entered
    always_ff @(posedge CLK_12M or negedge RESET_N) begin
        if (!RESET_N) begin
            r_scnt <= '0;
        end else if ((w_state_nxt != r_state) &&
                     ((w_state_nxt == S_SETTLE1) || (w_state_nxt == S_SETTLE2))) begin
            r_scnt <= SW'(SETTLE - 1);
        end else if (r_scnt != '0) begin
            r_scnt <= r_scnt - 1'b1;
        end
    end

    // Sample-window counters and candidate; cleared on leaving a sample state
    always_ff @(posedge CLK_12M or negedge RESET_N) begin
        if (!RESET_N) begin
            r_tcnt <= '0;
            r_mcnt <= '0;
            r_cand <= 8'hFF;
        end else if (w_in_sample && !w_done) begin
            r_tcnt <= w_tcnt_nxt;
            r_mcnt <= w_mcnt_nxt;
            r_cand <= w_sample;
        end else begin
            r_tcnt <= '0;
            r_mcnt <= '0;
        end
    end

    // Staging: an accepted word replaces the old one; a timeout keeps it and flags it
    always_ff @(posedge CLK_12M or negedge RESET_N) begin
        if (!RESET_N) begin
            r_stg1 <= 8'hFF;
            r_stg2 <= 8'hFF;
            r_err1 <= 1'b0;
            r_err2 <= 1'b0;
        end else if (r_state == S_SAMPLE1) begin
            if (w_accept) begin
                r_stg1 <= w_sample;
                r_err1 <= 1'b0;
            end else if (w_tmo) begin
                r_err1 <= 1'b1;
            end
        end else if (r_state == S_SAMPLE2) begin
            if (w_accept) begin
                r_stg2 <= w_sample;
                r_err2 <= 1'b0;
            end else if (w_tmo) begin
                r_err2 <= 1'b1;
            end
        end
    end

    // Registered outputs: select follows the upcoming state, publish loads the words
    always_ff @(posedge CLK_12M or negedge RESET_N) begin
        if (!RESET_N) begin
            r_jsel  <= 1'b0;
            r_joy1  <= 8'hFF;
            r_joy2  <= 8'hFF;
            r_valid <= 1'b0;
            r_err   <= 2'b00;
        end else begin
            r_jsel  <= (w_state_nxt == S_SETTLE2) || (w_state_nxt == S_SAMPLE2) ||
                       (w_state_nxt == S_PUBLISH);
            r_valid <= (r_state == S_PUBLISH);
            if (r_state == S_PUBLISH) begin
                r_joy1 <= r_stg1;
                r_joy2 <= r_stg2;
                r_err  <= {r_err2, r_err1};
            end
        end
    end

    assign bus.JSELECT   = r_jsel;
    assign bus.JOY1      = r_joy1;
    assign bus.JOY2      = r_joy2;
    assign bus.JOY_VALID = r_valid;
    assign bus.JOY_ERR   = r_err;
endmodule

// File: tb/tb_jamma_joy_scan_ctrl.sv
// Scoreboard bench for jamma_joy_scan_ctrl: the stimulus pushes expected
// frames (words, error flags, arrival cycle); a monitor pops on JOY_VALID.
module tb_jamma_joy_scan_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] p1 = 8'hFF;
    logic [7:0] p2 = 8'hFF;
    logic       tog = 1'b0;
    logic [7:0] tgl_val = 8'h00;

    typedef struct {
        logic [7:0] j1;
        logic [7:0] j2;
        logic [1:0] err;
        int         at;
    } exp_t;
    exp_t q[$];

    jamma_joy_scan_if bus ();

    // Splitter model: select chooses which player drives the bus
    assign bus.JJOY = bus.JSELECT ? (tog ? tgl_val : p2) : p1;

    jamma_joy_scan_ctrl #(.SETTLE(8), .SAMPLES(3), .TIMEOUT(16)) dut (
        .CLK_12M (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) tgl_val <= ~tgl_val;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic go(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] j1, input logic [7:0] j2,
                        input logic [1:0] err, input int at);
        exp_t e;
        e.j1 = j1; e.j2 = j2; e.err = err; e.at = at;
        q.push_back(e);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_jselect"}, bus.JSELECT, 1'b0);
        chk({tag, "_joy1"}, bus.JOY1, 8'hFF);
        chk({tag, "_joy2"}, bus.JOY2, 8'hFF);
        chk({tag, "_valid"}, bus.JOY_VALID, 1'b0);
        chk({tag, "_err"}, bus.JOY_ERR, 2'b00);
    endtask

    // Monitor: every valid pulse must match the oldest expected frame
    always @(negedge clk) begin
        if (bus.JOY_VALID === 1'b1) begin
            chk("valid_expected", (q.size() != 0), 1'b1);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("joy1", bus.JOY1, e.j1);
                chk("joy2", bus.JOY2, e.j2);
                chk("joy_err", bus.JOY_ERR, e.err);
                chk("valid_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r;
        bus.ENABLE   = 1'b1;
        bus.JOYSTICK = 6'h15;
        p1 = 8'h3C;
        p2 = 8'hC3;
        #2 rst_n = 1'b0;

        // Reset held with busy inputs
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset_hold");
        p1 = 8'($urandom);
        bus.JOYSTICK = 6'($urandom);
        @(negedge clk);
        chk("reset_hold2_jselect", bus.JSELECT, 1'b0);
        chk("reset_hold2_valid", bus.JOY_VALID, 1'b0);
        bus.ENABLE = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Static frames, then ENABLE dropped during SETTLE2 of frame 3
        p1 = 8'hA5; p2 = 8'h5A; bus.JOYSTICK = 6'b111110;
        n = cyc;
        bus.ENABLE = 1'b1;
        push(8'hA4, 8'h5A, 2'b00, n + 24);
        push(8'hA4, 8'h5A, 2'b00, n + 47);
        push(8'hA4, 8'h5A, 2'b00, n + 70);
        go(n + 23);
        chk("jselect_in_publish", bus.JSELECT, 1'b1);
        go(n + 24);
        chk("jselect_after_publish", bus.JSELECT, 1'b0);
        go(n + 62);
        bus.ENABLE = 1'b0;
        go(n + 69);
        chk("jselect_last_publish", bus.JSELECT, 1'b1);
        go(n + 70);
        chk("jselect_back_to_p1", bus.JSELECT, 1'b0);
        go(n + 100);
        chk("jselect_idle", bus.JSELECT, 1'b0);

        // Bounce on player 1; junk on the bus during settle must be ignored
        bus.JOYSTICK = 6'h3F; p1 = 8'h77; p2 = 8'h33;
        n = cyc;
        bus.ENABLE = 1'b1;
        push(8'hF0, 8'h33, 2'b00, n + 27);
        push(8'hF0, 8'h33, 2'b00, n + 50);
        go(n + 9);  p1 = 8'hF0;
        go(n + 11); p1 = 8'hF1;
        go(n + 12); p1 = 8'hF0;
        go(n + 27); bus.ENABLE = 1'b0;
        go(n + 80);

        // Player 2 toggles every cycle: timeout, then a clean frame clears the flag
        p1 = 8'h12; p2 = 8'h44; tog = 1'b1;
        n = cyc;
        bus.ENABLE = 1'b1;
        push(8'h12, 8'h33, 2'b10, n + 37);
        push(8'h12, 8'h44, 2'b00, n + 60);
        go(n + 37); tog = 1'b0;
        go(n + 40); bus.ENABLE = 1'b0;
        go(n + 90);

        // Reset in the middle of SAMPLE2 discards the frame
        p1 = 8'h11; p2 = 8'h22;
        n = cyc;
        bus.ENABLE = 1'b1;
        go(n + 21);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("reset_mid");
        go(n + 24);
        chk("reset_mid_valid_held", bus.JOY_VALID, 1'b0);
        rst_n = 1'b1;
        r = cyc;
        push(8'h11, 8'h22, 2'b00, r + 24);
        go(r + 5); bus.ENABLE = 1'b0;
        go(r + 70);

        chk("scoreboard_drained", q.size(), 0);
        chk("final_jselect", bus.JSELECT, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
